div_unit: RTL and testbench



---
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative signed restoring divider: one quotient bit per clock, truncating toward zero.
// Define DIV_REMAINDER_EN to add the remainder output port and its register.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             exception,
    output logic             data_ready,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_dvsr;
    logic [CW-1:0]      r_cnt;
    logic               r_sign_q;
    logic [WIDTH-1:0]   r_quot;
    logic               r_exc;
`ifdef DIV_REMAINDER_EN
    logic               r_sign_r;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   w_hi;
`endif

    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_dvnd;
    logic [WIDTH-1:0]   w_abs_dvsr;
    logic [2*WIDTH-1:0] w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_next;
    logic [WIDTH-1:0]   w_lo;
    logic               w_last;

    assign w_accept   = start && (r_state != S_BUSY);
    assign w_abs_dvnd = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_abs_dvsr = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Partial remainder stays below |divisor| <= 2^(W-1), so the bit shifted out is always 0.
    assign w_shift = {r_work[2*WIDTH-2:0], 1'b0};
    assign w_trial = {1'b0, w_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_dvsr};
    assign w_next  = w_trial[WIDTH] ? w_shift
                                    : {w_trial[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};
    assign w_lo    = w_next[WIDTH-1:0];
    assign w_last  = (r_cnt == CW'(WIDTH-1));
`ifdef DIV_REMAINDER_EN
    assign w_hi    = w_next[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_quot   <= '0;
            r_exc    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            r_sign_r <= 1'b0;
            r_rem    <= '0;
`endif
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_quot  <= r_sign_q ? -w_lo : w_lo;
                        // Only a positive quotient of magnitude 2^(W-1) overflows.
                        r_exc   <= !r_sign_q && w_lo[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                        r_rem   <= r_sign_r ? -w_hi : w_hi;
`endif
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                        r_sign_r <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            r_state <= S_DONE;
                            r_quot  <= '0;
                            r_exc   <= 1'b1;
`ifdef DIV_REMAINDER_EN
                            r_rem   <= dividend;
`endif
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= '0;
                            r_work  <= {{WIDTH{1'b0}}, w_abs_dvnd};
                            r_dvsr  <= w_abs_dvsr;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign quotient   = r_quot;
    assign exception  = r_exc;
    assign data_ready = (r_state == S_DONE);
    assign busy       = (r_state == S_BUSY);
`ifdef DIV_REMAINDER_EN
    assign remainder  = r_rem;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic reference model with per-cycle compare, directed corner cases
// and randomized operands. Remainder is checked only when DIV_REMAINDER_EN is defined.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
`ifdef DIV_REMAINDER_EN
    logic [31:0] remainder;
`endif
    logic        exception;
    logic        data_ready;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
`ifdef DIV_REMAINDER_EN
        .remainder  (remainder),
`endif
        .exception  (exception),
        .data_ready (data_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } res_t;

    // Reference result from plain 64-bit signed arithmetic.
    function automatic res_t calc(input logic [31:0] a, input logic [31:0] b);
        res_t   res;
        longint sa, sb, q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            res.q = '0;
            res.r = a;
            res.e = 1'b1;
        end else begin
            q64   = sa / sb;
            r64   = sa % sb;
            res.q = q64[31:0];
            res.r = r64[31:0];
            res.e = (q64 == 64'sd2147483648);
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: a countdown of remaining busy cycles plus the last delivered result.
    int   m_cnt;
    logic m_rdy;
    res_t m_out;
    res_t m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_rdy  <= 1'b0;
            m_out  <= '0;
            m_pend <= '0;
        end else if (start && m_cnt == 0) begin
            if (divisor == 32'd0) begin
                m_rdy <= 1'b1;
                m_out <= calc(dividend, divisor);
            end else begin
                m_rdy  <= 1'b0;
                m_cnt  <= 32;
                m_pend <= calc(dividend, divisor);
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            m_rdy <= (m_cnt == 1);
            if (m_cnt == 1) m_out <= m_pend;
        end else begin
            m_rdy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy",       32'(busy),       32'(m_cnt != 0));
        chk("data_ready", 32'(data_ready), 32'(m_rdy));
        chk("quotient",   quotient,        m_out.q);
        chk("exception",  32'(exception),  32'(m_out.e));
`ifdef DIV_REMAINDER_EN
        chk("remainder",  remainder,       m_out.r);
`endif
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_ready(input int lat0, output int lat, output int nb);
        lat = lat0;
        nb  = 0;
        while (!data_ready && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        if (!data_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got no data_ready expected pulse within 40 cycles at %0t", $time);
        end
    endtask

    task automatic check_res(input string name, input logic [31:0] q, input logic [31:0] r,
                             input logic e);
        chk({name, "_q"}, quotient, q);
        chk({name, "_e"}, 32'(exception), 32'(e));
`ifdef DIV_REMAINDER_EN
        chk({name, "_r"}, remainder, r);
`else
        if (r === 32'hxxxxxxxx) $display("unused remainder literal");
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int   lat, nb;
        res_t mr;
        logic [31:0] a, b;

        // Model pins against hand-computed values.
        mr = calc(32'd100, 32'd7);
        chk("model_100_7_q", mr.q, 32'd14);
        chk("model_100_7_r", mr.r, 32'd2);
        mr = calc(32'hFFFFFF9C, 32'd7);
        chk("model_m100_7_q", mr.q, 32'hFFFFFFF2);
        chk("model_m100_7_r", mr.r, 32'hFFFFFFFE);
        mr = calc(32'h80000000, 32'hFFFFFFFF);
        chk("model_ovf_e", 32'(mr.e), 32'd1);

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_quot",  quotient,        32'd0);
        chk("rst_exc",   32'(exception),  32'd0);
        #2 reset = 1'b0;

        @(negedge clk); issue(32'd100, 32'd7); wait_ready(1, lat, nb);
        chk("lat_100_7", 32'(lat), 32'd33);
        chk("busy_100_7", 32'(nb), 32'd32);
        check_res("d100_7", 32'd14, 32'd2, 1'b0);

        @(negedge clk); issue(32'hFFFFFF9C, 32'd7); wait_ready(1, lat, nb);
        check_res("dm100_7", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);

        @(negedge clk); issue(32'd100, 32'hFFFFFFF9); wait_ready(1, lat, nb);
        check_res("d100_m7", 32'hFFFFFFF2, 32'd2, 1'b0);

        @(negedge clk); issue(32'd7, 32'd0); wait_ready(1, lat, nb);
        chk("lat_div0", 32'(lat), 32'd1);
        chk("busy_div0", 32'(nb), 32'd0);
        check_res("d7_0", 32'd0, 32'd7, 1'b1);

        @(negedge clk); issue(32'h80000000, 32'hFFFFFFFF); wait_ready(1, lat, nb);
        check_res("dmin_m1", 32'h80000000, 32'd0, 1'b1);

        @(negedge clk); issue(32'h80000000, 32'd1); wait_ready(1, lat, nb);
        check_res("dmin_1", 32'h80000000, 32'd0, 1'b0);

        // A start in the middle of BUSY must be ignored.
        @(negedge clk); issue(32'd200, 32'd10);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd5; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_ready(11, lat, nb);
        chk("lat_ignore", 32'(lat), 32'd33);
        check_res("ignore", 32'd20, 32'd0, 1'b0);

        // Back-to-back: next start issued in the DONE cycle.
        @(negedge clk); issue(32'd50, 32'd5); wait_ready(1, lat, nb);
        check_res("b2b_first", 32'd10, 32'd0, 1'b0);
        issue(32'hFFFFFFAF, 32'd9); wait_ready(1, lat, nb);
        chk("lat_b2b", 32'(lat), 32'd33);
        check_res("b2b_second", 32'hFFFFFFF7, 32'd0, 1'b0);

        // Reset in the middle of a division.
        @(negedge clk); issue(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_ready", 32'(data_ready), 32'd0);
        chk("mid_rst_quot",  quotient,        32'd0);
        chk("mid_rst_exc",   32'(exception),  32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_ready", 32'(data_ready), 32'd0);
        @(negedge clk); issue(32'd9, 32'd3); wait_ready(1, lat, nb);
        check_res("d9_3", 32'd3, 32'd0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1; end
                2: begin a = 32'($urandom_range(0, 1000)) - 32'd500; b = 32'($urandom_range(1, 20)); end
                3: begin a = $urandom; b = 32'd0 - 32'($urandom_range(1, 20)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b);
            if (b != 32'd0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                start = 1'b1; dividend = $urandom; divisor = $urandom;
                @(negedge clk);
                start = 1'b0;
            end
            wait_ready(1, lat, nb);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
